// File: rtl/cacheline_burst_adaptor_if.sv
// ---------------------------------------------------------------------------
// cacheline_burst_adaptor_if
//
// Purpose: bundles the cache-side line port and the memory-side burst port
// of the cacheline burst adaptor into a single interface.
//
// Signals (directions as seen by the adaptor, i.e. the slave modport):
//   line_addr_i   in   ADDR_WIDTH   cache line byte address (offset bits ignored)
//   line_read_i   in   1            cache read request, held until resp_o
//   line_write_i  in   1            cache write request, held until resp_o
//   line_data_i   in   LINE_WIDTH   write-back line
//   line_data_o   out  LINE_WIDTH   fetched line
//   resp_o        out  1            completion pulse to the cache
//   mem_addr_o    out  ADDR_WIDTH   line-aligned burst address
//   mem_read_o    out  1            burst read request
//   mem_write_o   out  1            burst write request
//   mem_wdata_o   out  BURST_WIDTH  current write beat
//   mem_rdata_i   in   BURST_WIDTH  current read beat
//   mem_resp_i    in   1            one beat transferred in each cycle it is high
//
// Modports:
//   slave  - the adaptor itself
//   master - the environment (cache controller + memory model)
// ---------------------------------------------------------------------------
interface cacheline_burst_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);

  logic [ADDR_WIDTH-1:0]  line_addr_i;
  logic                   line_read_i;
  logic                   line_write_i;
  logic [LINE_WIDTH-1:0]  line_data_i;
  logic [LINE_WIDTH-1:0]  line_data_o;
  logic                   resp_o;

  logic [ADDR_WIDTH-1:0]  mem_addr_o;
  logic                   mem_read_o;
  logic                   mem_write_o;
  logic [BURST_WIDTH-1:0] mem_wdata_o;
  logic [BURST_WIDTH-1:0] mem_rdata_i;
  logic                   mem_resp_i;

  modport slave (
    input  line_addr_i,
    input  line_read_i,
    input  line_write_i,
    input  line_data_i,
    output line_data_o,
    output resp_o,
    output mem_addr_o,
    output mem_read_o,
    output mem_write_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_resp_i
  );

  modport master (
    output line_addr_i,
    output line_read_i,
    output line_write_i,
    output line_data_i,
    input  line_data_o,
    input  resp_o,
    input  mem_addr_o,
    input  mem_read_o,
    input  mem_write_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_resp_i
  );

endinterface

// File: rtl/cacheline_burst_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_burst_adaptor
//
// Purpose: memory-side responder for the cache line port. Accepts whole-line
// read/write requests and serves them as BEATS = LINE_WIDTH/BURST_WIDTH
// sequential beats on a narrower burst memory interface, then pulses resp_o
// to the cache. Beat k is line bits [k*BURST_WIDTH +: BURST_WIDTH].
//
// Ports:
//   clk   in  clock, all state changes on posedge
//   rst   in  synchronous active-high reset
//   bus   cacheline_burst_adaptor_if.slave (cache line port + burst port)
//
// Build option:
//   CACHELINE_ADAPTOR_FAST_RESP_EN - when defined, the DONE state is removed;
//   resp_o is raised combinationally during the last beat handshake and the
//   final read beat is forwarded straight onto line_data_o in that cycle.
//   When undefined, resp_o is a registered pulse one cycle after the last
//   beat (DONE state).
// ---------------------------------------------------------------------------
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input logic                      clk,
  input logic                      rst,
  cacheline_burst_adaptor_if.slave bus
);

  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFFS_W = $clog2(LINE_WIDTH / 8);

  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);
  // Clears the byte-offset bits of the line address.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFS_W;

`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;
`endif

  state_t                  state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [LINE_WIDTH-1:0]   wbuf_q,      wbuf_d;   // latched write-back line
  logic [LINE_WIDTH-1:0]   rbuf_q,      rbuf_d;   // fetched line buffer
  logic                    mem_read_q,  mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [BURST_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
`ifndef CACHELINE_ADAPTOR_FAST_RESP_EN
  logic                    resp_q,      resp_d;
`endif

  logic                    last_beat;

  // Write-back line viewed as an array of beats so the current beat can be
  // selected by the counter.
  logic [BURST_WIDTH-1:0]  wbeat [BEATS];

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
    assign wbeat[gi] = wbuf_q[gi*BURST_WIDTH +: BURST_WIDTH];
  end

  // Handshake of the final beat of the current burst.
  assign last_beat = bus.mem_resp_i && (cnt_q == LAST_CNT);

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_wdata_d = '0;
`ifndef CACHELINE_ADAPTOR_FAST_RESP_EN
    resp_d      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Write wins when both requests are present; the read stays pending
        // at the cache and is picked up after this write completes.
        if (bus.line_write_i) begin
          addr_d      = bus.line_addr_i & ADDR_MASK;
          wbuf_d      = bus.line_data_i;
          cnt_d       = '0;
          state_d     = WR_BURST;
          mem_write_d = 1'b1;
          mem_wdata_d = bus.line_data_i[BURST_WIDTH-1:0];
        end else if (bus.line_read_i) begin
          addr_d      = bus.line_addr_i & ADDR_MASK;
          cnt_d       = '0;
          state_d     = RD_BURST;
          mem_read_d  = 1'b1;
        end
      end

      RD_BURST: begin
        mem_read_d = 1'b1;
        if (bus.mem_resp_i) begin
          // Beats land directly in the visible line buffer, so the previous
          // line remains on line_data_o until the first beat of this read.
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
              rbuf_d[b*BURST_WIDTH +: BURST_WIDTH] = bus.mem_rdata_i;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            mem_read_d = 1'b0;
`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
            state_d    = IDLE;
`else
            state_d    = DONE;
            resp_d     = 1'b1;
`endif
          end
        end
      end

      WR_BURST: begin
        mem_write_d = 1'b1;
        mem_wdata_d = wbeat[cnt_q];
        if (bus.mem_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            mem_write_d = 1'b0;
            mem_wdata_d = '0;
`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
            state_d     = IDLE;
`else
            state_d     = DONE;
            resp_d      = 1'b1;
`endif
          end else begin
            // Present the following beat in the cycle after the handshake.
            mem_wdata_d = wbeat[cnt_d];
          end
        end
      end

`ifndef CACHELINE_ADAPTOR_FAST_RESP_EN
      // The cache still holds its request while it sees resp_o, so requests
      // are deliberately not sampled here.
      DONE: begin
        state_d = IDLE;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wbuf_q      <= '0;
      rbuf_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
`ifndef CACHELINE_ADAPTOR_FAST_RESP_EN
      resp_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
`ifndef CACHELINE_ADAPTOR_FAST_RESP_EN
      resp_q      <= resp_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_read_o  = mem_read_q;
  assign bus.mem_write_o = mem_write_q;
  assign bus.mem_wdata_o = mem_wdata_q;

`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
  logic read_done;
  assign read_done  = (state_q == RD_BURST) && last_beat;
  assign bus.resp_o = ((state_q == RD_BURST) || (state_q == WR_BURST)) && last_beat;

  // The top slice forwards the final read beat in its handshake cycle so the
  // cache sees the complete line together with resp_o.
  always_comb begin
    bus.line_data_o = rbuf_q;
    if (read_done) begin
      bus.line_data_o[(BEATS-1)*BURST_WIDTH +: BURST_WIDTH] = bus.mem_rdata_i;
    end
  end
`else
  assign bus.resp_o      = resp_q;
  assign bus.line_data_o = rbuf_q;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
`timescale 1ns/1ps
// Self-checking bench for cacheline_burst_adaptor. A transaction-level model
// predicts, cycle by cycle, which beat the memory side should present, when
// the completion pulse appears and what line the cache should read back.
module tb_cacheline_burst_adaptor;

  localparam int LW    = 256;
  localparam int BW    = 64;
  localparam int AW    = 32;
  localparam int BEATS = LW / BW;
`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  cacheline_burst_adaptor #(
    .LINE_WIDTH (LW),
    .BURST_WIDTH(BW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [LW-1:0] model_line = '0;   // line the cache should currently see

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  // One cache transaction. Starts in a fresh cycle with the adaptor idle,
  // raises the request(s), plays memory with pattern pat (first plen cycles)
  // followed by random handshakes, and ends in the resp_o cycle.
  task automatic do_xfer(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wline, input logic [LW-1:0] rline,
                         input logic [15:0] pat, input int plen, output int resp_at);
    logic [AW-1:0] exp_addr;
    int  hs;
    int  c;
    bit  done;
    bit  beat;
    bit  exp_resp;
    bit  active;
    exp_addr = addr - (addr % (LW / 8));
    hs = 0;
    c = 0;
    done = 0;
    resp_at = -1;
    tick();
    bus.line_read_i  = rd;
    bus.line_write_i = wr;
    bus.line_addr_i  = addr;
    bus.line_data_i  = wline;
    bus.mem_resp_i   = 1'($urandom_range(0, 1));   // ignored while idle
    bus.mem_rdata_i  = rand_beat();
    #1;
    chk("idle_resp", bus.resp_o, 1'b0);
    chk("idle_mem_req", {bus.mem_read_o, bus.mem_write_o}, 2'b00);
    while (!done && c < 64) begin
      tick();
      c++;
      // Cache-side data/address wander mid-burst; the latched copies rule.
      bus.line_addr_i = $urandom;
      bus.line_data_i = rand_line();
      if (c - 1 < plen) beat = pat[c-1];
      else              beat = ($urandom_range(0, 3) != 0);
      active = (hs < BEATS);
      bus.mem_resp_i  = beat;
      bus.mem_rdata_i = (active && beat) ? rline[hs*BW +: BW] : rand_beat();
      #1;
      exp_resp = (FAST != 0) ? (hs == BEATS - 1 && beat) : (hs == BEATS);
      chk("resp", bus.resp_o, exp_resp);
      chk("mem_read", bus.mem_read_o, active && !wr);
      chk("mem_write", bus.mem_write_o, active && wr);
      if (active) chk("mem_addr", bus.mem_addr_o, exp_addr);
      if (active && wr) chk("mem_wdata", bus.mem_wdata_o, wline[hs*BW +: BW]);
      if (exp_resp) begin
        if (!wr) model_line = rline;
        chk("line_data", bus.line_data_o, model_line);
        resp_at = c;
        done = 1;
      end else if (wr) begin
        chk("line_hold", bus.line_data_o, model_line);
      end
      if (active && beat) hs++;
    end
    if (!done) chk("resp_timeout", 1'b0, 1'b1);
    $display("xfer %s addr=%h beats=%0d resp_cycle=%0d", wr ? "WR" : "RD", addr, hs, resp_at);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int            r;
    logic [LW-1:0] l0;
    logic [LW-1:0] l1;
    logic [AW-1:0] a;
    bit            w;

    bus.line_addr_i  = '0;
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.line_data_i  = '0;
    bus.mem_rdata_i  = '0;
    bus.mem_resp_i   = 1'b0;

    // Reset held two cycles with stray handshakes and a request present.
    rst = 1'b1;
    tick();
    bus.mem_resp_i  = 1'b1;
    bus.line_read_i = 1'b1;
    bus.mem_rdata_i = rand_beat();
    tick();
    chk("rst_resp", bus.resp_o, 1'b0);
    chk("rst_mem_read", bus.mem_read_o, 1'b0);
    chk("rst_mem_write", bus.mem_write_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, '0);
    chk("rst_mem_wdata", bus.mem_wdata_o, '0);
    chk("rst_line_data", bus.line_data_o, '0);
    $display("reset checked");
    rst = 1'b0;
    bus.mem_resp_i  = 1'b0;
    bus.line_read_i = 1'b0;

    // Back-to-back read of 0x1234.
    l0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_xfer(1, 0, 32'h0000_1234, '0, l0, 16'hFFFF, 4, r);
    chk("rd_latency", r, BEATS + 1 - FAST);
    chk("rd_line_const", bus.line_data_o, l0);

    // Write with gaps 1,0,0,1,1,0,1.
    l1 = {64'hDEAD_0003_3333_BEEF, 64'hDEAD_0002_2222_BEEF,
          64'hDEAD_0001_1111_BEEF, 64'hDEAD_0000_0000_BEEF};
    do_xfer(0, 1, 32'h0000_8040, l1, '0, 16'h0059, 7, r);
    chk("wr_gap_latency", r, 8 - FAST);

    // Both requests: write first, read served afterwards.
    do_xfer(1, 1, 32'hABCD_0010, rand_line(), '0, 16'h0000, 0, r);
    do_xfer(1, 0, 32'hABCD_0010, '0, rand_line(), 16'h0000, 0, r);

    // Reset after two read beats.
    tick();
    bus.line_read_i  = 1'b1;
    bus.line_write_i = 1'b0;
    bus.line_addr_i  = 32'h0000_2000;
    bus.mem_resp_i   = 1'b0;
    tick();
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = rand_beat();
    tick();
    bus.mem_rdata_i = rand_beat();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_mem_read", bus.mem_read_o, 1'b0);
    chk("abort_resp", bus.resp_o, 1'b0);
    chk("abort_line", bus.line_data_o, '0);
    $display("reset mid-burst checked");
    rst = 1'b0;
    bus.line_read_i = 1'b0;
    bus.mem_resp_i  = 1'b0;
    model_line = '0;
    do_xfer(1, 0, 32'h0000_2000, '0, rand_line(), 16'h0000, 0, r);

    // Write-back then fill in the cycle after resp_o.
    do_xfer(0, 1, 32'h0001_0000, rand_line(), '0, 16'h0000, 0, r);
    do_xfer(1, 0, 32'h0002_0020, '0, rand_line(), 16'h0000, 0, r);

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      w = 1'($urandom_range(0, 1));
      do_xfer(!w, w, a, rand_line(), rand_line(), 16'h0000, 0, r);
    end

    tick();
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.mem_resp_i   = 1'b1;
    #1;
    chk("final_idle_resp", bus.resp_o, 1'b0);
    tick();
    chk("final_idle_req", {bus.mem_read_o, bus.mem_write_o}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
